div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port signed_div_i  input  1  1 = two's-complement division, 0 = unsigned.
REQ-005 SHALL have port opdata1_i  input  WIDTH  dividend.
REQ-006 SHALL have port opdata2_i  input  WIDTH  divisor.
REQ-007 SHALL have port start_i  input  1  request; held high until the result is consumed.
REQ-008 SHALL have port annul_i  input  1  cancel the in-flight operation.
REQ-009 SHALL have port result_o  output  2*WIDTH  {remainder, quotient}, quotient in the low half.
REQ-010 SHALL have port ready_o  output  1  result_o valid.
REQ-011 SHALL have port busy_o  output  1  high in every state other than IDLE.
REQ-012 SHALL have port div_zero_o  output  1  current result came from a zero divisor.

Function
REQ-013 SHALL implement four states: IDLE, BYZERO, ON and END.
REQ-014 In IDLE, start_i=1 with annul_i=0 SHALL be accepted: opdata2_i==0 -> BYZERO; otherwise -> ON, with cnt cleared.
REQ-015 On accept, the block SHALL latch |opdata1_i| and |opdata2_i| (magnitudes taken only when signed_div_i=1), plus signed_div_i and both operand sign bits.
REQ-016 Operand inputs SHALL be don't-care after the accept edge.
REQ-017 In ON, each cycle SHALL perform one restoring shift-subtract step on a (2*WIDTH+1)-bit partial register, using a WIDTH+1-bit trial subtraction.
REQ-018 cnt SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-019 After WIDTH steps, one further ON cycle SHALL apply the sign fix and move to END:
  - quotient is negated when signed and the latched signs differ;
  - remainder is negated when signed and the latched dividend sign is 1.
REQ-020 In BYZERO, the block SHALL clear the partial register, set an internal zero flag, and move to END after one cycle.
REQ-021 In END, result_o, ready_o=1 and div_zero_o SHALL be registered; they SHALL hold while start_i=1.
REQ-022 In END, start_i=0 SHALL return the block to IDLE on that edge, with ready_o=0, div_zero_o=0 and result_o=0.
REQ-023 ready_o SHALL first be observed high WIDTH+2 edges after the accept edge for a nonzero divisor (34 for WIDTH=32), and 2 edges after it for a zero divisor.
REQ-024 Signed results SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-025 Most-negative / -1 SHALL give quotient = most-negative value (wrap) and remainder 0, with no flag.
REQ-026 annul_i=1 in ON SHALL force IDLE on the next edge, leaving ready_o=0 and result_o=0.
REQ-027 annul_i=1 in BYZERO or END SHALL have no effect.
REQ-028 start_i=1 together with annul_i=1 in IDLE SHALL not be accepted.
REQ-029 In IDLE without an accept, ready_o, div_zero_o and result_o SHALL be 0.
REQ-030 A new operation SHALL require at least one IDLE cycle; back-to-back accepts from END are not allowed.

Reset
REQ-031 While rst=1, state SHALL be IDLE, cnt SHALL be 0, ready_o=0, busy_o=0, div_zero_o=0 and result_o=0, independent of clk.
REQ-032 rst asserted in any state, including mid-ON, SHALL abort the operation; after release the block SHALL accept a new start normally.

Verification
REQ-033 Unsigned case: WIDTH=32, 100/7, start held -> ready_o high at edge 34 after accept, quotient 14, remainder 2, div_zero_o=0.
REQ-034 Signed cases: WIDTH=32, -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-035 Zero divisor: 5/0 -> ready_o at edge 2, result_o=0, div_zero_o=1; start_i dropped -> IDLE, all outputs 0.
REQ-036 Annul: annul_i pulsed at cnt=10 -> IDLE next edge, ready_o never high; a following 9/3 -> quotient 3, remainder 0.
REQ-037 Overflow wrap: WIDTH=8, signed -128/-1 -> quotient 0x80, remainder 0x00; unsigned 255/16 -> quotient 15, remainder 15, ready_o at edge 10.
REQ-038 Reset and operand change: rst raised asynchronously mid-ON -> outputs 0 immediately; after release, operands changed every cycle after accept -> result matches the operands latched at accept.

Source files
------------

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative restoring divider, signed or unsigned, one quotient
// bit per clock.
//
// Parameters
//   WIDTH         operand width (4..64)
//
// Ports
//   clk           clock, all state changes on its rising edge
//   rst           asynchronous active-high reset
//   signed_div_i  1 = two's-complement division, 0 = unsigned
//   opdata1_i     dividend, sampled only on the accept edge
//   opdata2_i     divisor, sampled only on the accept edge
//   start_i       request; held high until the result has been consumed
//   annul_i       cancel an operation that is still iterating
//   result_o      {remainder, quotient}, quotient in the low half
//   ready_o       result_o valid
//   busy_o        high whenever the block is not idle
//   div_zero_o    current result came from a zero divisor
//
// Timing: accept edge -> WIDTH iteration edges -> one sign-fix edge -> END.
// The first END edge registers the result, so ready_o rises WIDTH+2 edges
// after accept (2 edges for a zero divisor, which skips the iterations).
// -----------------------------------------------------------------------------
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 div_zero_o
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   typedef enum logic [1:0] {
      StIdle,
      StByZero,
      StOn,
      StEnd
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Partial register layout while iterating:
   //   [2W:W]   shifted partial remainder (next trial operand)
   //   [W-1:0]  remaining dividend bits on top, quotient bits filling from 0
   // After the last step the remainder sits in [2W:W+1] and bit W is a
   // leftover shift bit with no meaning.
   logic [2*WIDTH:0]     part_q, part_d;
   logic [WIDTH-1:0]     divisor_q, divisor_d;
   logic                 signed_q, signed_d;
   logic                 sign1_q, sign1_d;
   logic                 sign2_q, sign2_d;
   logic                 zero_q, zero_d;

   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 ready_q, ready_d;
   logic                 div_zero_q, div_zero_d;

   // Operand magnitudes, only taken for signed division.
   logic [WIDTH-1:0]     mag1, mag2;
   // One restoring step.
   logic [WIDTH:0]       trial;
   logic [2*WIDTH:0]     step_part;
   // Sign correction applied once after the last step.
   logic [WIDTH-1:0]     quo_raw, rem_raw;
   logic [WIDTH-1:0]     quo_fix, rem_fix;
   logic                 neg_quo, neg_rem;

   always_comb begin
      mag1 = opdata1_i;
      mag2 = opdata2_i;
      if (signed_div_i && opdata1_i[WIDTH-1]) begin
         mag1 = {WIDTH{1'b0}} - opdata1_i;
      end
      if (signed_div_i && opdata2_i[WIDTH-1]) begin
         mag2 = {WIDTH{1'b0}} - opdata2_i;
      end
   end

   // The partial remainder is always below 2*divisor, so a WIDTH+1 bit
   // subtraction is enough and trial[WIDTH] is a true "less than" flag.
   always_comb begin
      trial = part_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
      if (trial[WIDTH]) begin
         step_part = {part_q[2*WIDTH-1:0], 1'b0};
      end else begin
         step_part = {trial[WIDTH-1:0], part_q[WIDTH-1:0], 1'b1};
      end
   end

   always_comb begin
      quo_raw = part_q[WIDTH-1:0];
      rem_raw = part_q[2*WIDTH:WIDTH+1];
      neg_quo = signed_q && (sign1_q ^ sign2_q);
      neg_rem = signed_q && sign1_q;
      quo_fix = neg_quo ? ({WIDTH{1'b0}} - quo_raw) : quo_raw;
      rem_fix = neg_rem ? ({WIDTH{1'b0}} - rem_raw) : rem_raw;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      part_d     = part_q;
      divisor_d  = divisor_q;
      signed_d   = signed_q;
      sign1_d    = sign1_q;
      sign2_d    = sign2_q;
      zero_d     = zero_q;
      result_d   = result_q;
      ready_d    = ready_q;
      div_zero_d = div_zero_q;

      unique case (state_q)
         StIdle: begin
            result_d   = '0;
            ready_d    = 1'b0;
            div_zero_d = 1'b0;
            if (start_i && !annul_i) begin
               part_d    = {{WIDTH{1'b0}}, mag1, 1'b0};
               divisor_d = mag2;
               signed_d  = signed_div_i;
               sign1_d   = opdata1_i[WIDTH-1];
               sign2_d   = opdata2_i[WIDTH-1];
               zero_d    = 1'b0;
               cnt_d     = '0;
               if (opdata2_i == '0) begin
                  state_d = StByZero;
               end else begin
                  state_d = StOn;
               end
            end
         end

         StByZero: begin
            part_d  = '0;
            zero_d  = 1'b1;
            state_d = StEnd;
         end

         StOn: begin
            if (annul_i) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q != CNT_LAST) begin
               part_d = step_part;
               cnt_d  = cnt_q + CNT_W'(1);
            end else begin
               part_d  = {rem_fix, 1'b0, quo_fix};
               state_d = StEnd;
            end
         end

         StEnd: begin
            if (start_i) begin
               result_d   = {part_q[2*WIDTH:WIDTH+1], part_q[WIDTH-1:0]};
               ready_d    = 1'b1;
               div_zero_d = zero_q;
            end else begin
               result_d   = '0;
               ready_d    = 1'b0;
               div_zero_d = 1'b0;
               state_d    = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         part_q     <= '0;
         divisor_q  <= '0;
         signed_q   <= 1'b0;
         sign1_q    <= 1'b0;
         sign2_q    <= 1'b0;
         zero_q     <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         part_q     <= part_d;
         divisor_q  <= divisor_d;
         signed_q   <= signed_d;
         sign1_q    <= sign1_d;
         sign2_q    <= sign2_d;
         zero_q     <= zero_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign result_o   = result_q;
   assign ready_o    = ready_q;
   assign div_zero_o = div_zero_q;
   assign busy_o     = (state_q != StIdle);

endmodule
